channel_sequencer: RTL and testbench

- Schedules per-sample channel accumulation over the shared operator-output memory.
- After the operator pipeline signals completion, walks every audible 2-op and 4-op channel across both banks.
- For each channel it issues a descriptor to the accumulator datapath, then a burst of operator-memory reads. Each read's tag is pipelined to line up with the memory's read latency.
- 2-op halves of 4-op pairs are skipped outright rather than computed and masked.

---
 rtl/opl3_pkg.sv | 95 +++++++++
 rtl/seq_tag_delay.sv | 47 ++++
 rtl/channel_sequencer.sv | 246 ++++++++++++++++++++++++
 tb/tb_channel_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/opl3_pkg.sv
// Shared types and slot/operator helpers for the per-sample channel sequencer.
// Latency: none; every helper here is pure combinational decode.
// Backpressure: none; the helpers carry no state.
package opl3_pkg;

    localparam int NUM_SEQ_SLOTS     = 24;
    localparam int OP_SLOT_IDX_WIDTH = 2;
    localparam int SEQ_SLOT_W        = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DESC  = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic       bank;
        logic [3:0] channel;
        logic       four_op;
    } seq_slot_t;

    typedef struct packed {
        logic                         valid;
        logic [OP_SLOT_IDX_WIDTH-1:0] idx;
        logic                         last;
        logic                         done;
    } seq_tag_t;

    // Slots 0..17 are the 2-op pass (bank0 ch0..8, bank1 ch0..8),
    // slots 18..23 the 4-op pass (bank0 pair0..2, bank1 pair0..2).
    // Subtraction is done mod 16 on the low nibble; the result always fits.
    function automatic seq_slot_t slot_decode(input logic [SEQ_SLOT_W-1:0] s);
        seq_slot_t r;
        r.four_op = (s >= 5'd18);
        if (s >= 5'd21) begin
            r.bank    = 1'b1;
            r.channel = s[3:0] - 4'd5;
        end else if (s >= 5'd18) begin
            r.bank    = 1'b0;
            r.channel = s[3:0] - 4'd2;
        end else if (s >= 5'd9) begin
            r.bank    = 1'b1;
            r.channel = s[3:0] - 4'd9;
        end else begin
            r.bank    = 1'b0;
            r.channel = s[3:0];
        end
        return r;
    endfunction

    // A 2-op channel belonging to an enabled 4-op pair is skipped; a 4-op
    // pair is skipped unless enabled. Channels 6..8 never pair up.
    function automatic logic slot_skipped(input seq_slot_t sl, input logic [5:0] sel);
        logic [1:0] pair;
        logic [2:0] k;
        logic       hit;
        if (sl.channel < 4'd3) begin
            pair = sl.channel[1:0];
        end else if (sl.channel < 4'd6) begin
            pair = 2'(sl.channel - 4'd3);
        end else begin
            pair = 2'd0;
        end
        k   = sl.bank ? (3'(pair) + 3'd3) : 3'(pair);
        hit = sel[k];
        if (sl.four_op) begin
            return !hit;
        end
        return (sl.channel < 4'd6) ? hit : 1'b0;
    endfunction

    // Operator index inside the bank for read number idx of a slot.
    function automatic logic [4:0] op_num_for(input seq_slot_t sl, input logic [1:0] idx);
        logic [4:0] c;
        logic [4:0] base;
        logic [4:0] off;
        c = {1'b0, sl.channel};
        case (idx)
            2'd0:    off = 5'd0;
            2'd1:    off = 5'd3;
            2'd2:    off = 5'd6;
            default: off = 5'd9;
        endcase
        if (sl.four_op || c < 5'd3) begin
            base = c;
        end else if (c < 5'd6) begin
            base = c + 5'd3;
        end else begin
            base = c + 5'd6;
        end
        return base + off;
    endfunction

endpackage

// File: rtl/seq_tag_delay.sv
// Delays read tags {valid, idx, last, done} to line up with operator-memory data.
// Latency: exactly LATENCY cycles from tag_in to tag_out.
// Backpressure: none; flush empties every stage on the next edge.
module seq_tag_delay
    import opl3_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     flush,
    input  seq_tag_t tag_in,
    output seq_tag_t tag_out
);

    seq_tag_t tag_q [LATENCY];
    seq_tag_t tag_d [LATENCY];

    // Shift one stage per cycle; a flush replaces everything with empty tags
    always_comb begin
        tag_d[0] = tag_in;
        for (int i = 1; i < LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end
        if (flush) begin
            for (int i = 0; i < LATENCY; i++) begin
                tag_d[i] = '0;
            end
        end
    end

    // Stage registers, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LATENCY; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign tag_out = tag_q[LATENCY-1];

endmodule

// File: rtl/channel_sequencer.sv
// Walks audible 2-op/4-op channels, issuing a descriptor then an operator-memory read burst each.
// Latency: descriptor 1 cycle after ops_done_pulse; 3/5 cycles per 2-op/4-op channel; data tags +MEM_LATENCY.
// Backpressure: descriptor held until ch_ready; reads never stall. CHANNEL_SEQ_STATS_EN adds cycle/stall counters.
module channel_sequencer
    import opl3_pkg::*;
#(
    parameter int NUM_BANKS              = 2,
    parameter int NUM_CHANNELS_PER_BANK  = 9,
    parameter int NUM_OPERATORS_PER_BANK = 18,
    parameter int MEM_LATENCY            = 1
) (
    input  logic                                      clk,
    input  logic                                      reset_n,
    input  logic                                      sample_clk_en,
    input  logic                                      ops_done_pulse,
    input  logic [5:0]                                connection_sel,
    input  logic                                      is_new,
    output logic                                      ch_valid,
    input  logic                                      ch_ready,
    output logic [$clog2(NUM_BANKS)-1:0]              ch_bank,
    output logic [$clog2(NUM_CHANNELS_PER_BANK)-1:0]  ch_num,
    output logic                                      ch_four_op,
    output logic                                      op_rd,
    output logic [$clog2(NUM_BANKS)-1:0]              op_rd_bank,
    output logic [$clog2(NUM_OPERATORS_PER_BANK)-1:0] op_rd_op_num,
    output logic                                      op_data_valid,
    output logic [OP_SLOT_IDX_WIDTH-1:0]              op_data_idx,
    output logic                                      op_data_last,
    output logic                                      seq_done,
    output logic                                      busy,
    output logic                                      overrun
`ifdef CHANNEL_SEQ_STATS_EN
    ,
    output logic [7:0]                                seq_cycles,
    output logic [7:0]                                stall_cycles
`endif
);

    seq_state_e state_q, state_d;
    logic [SEQ_SLOT_W-1:0] slot_q, slot_d;
    logic [1:0]            idx_q, idx_d;
    logic [1:0]            drain_q, drain_d;
    logic [5:0]            eff_sel_q, eff_sel_d;
    logic                  overrun_q, overrun_d;

    seq_slot_t             cur;
    logic                  last_rd;
    logic [5:0]            scan_sel;
    logic [SEQ_SLOT_W-1:0] scan_start;
    logic                  nxt_found;
    logic [SEQ_SLOT_W-1:0] nxt_slot;
    logic                  accept;
    seq_tag_t              tag_in, tag_out;

    assign cur     = slot_decode(slot_q);
    assign last_rd = (state_q == ST_READ) && (idx_q == (cur.four_op ? 2'd3 : 2'd1));
    assign accept  = (state_q == ST_IDLE) && ops_done_pulse && !sample_clk_en;

    // Priority-encode the next unskipped slot; in IDLE use the live selection being snapshotted
    always_comb begin
        scan_sel   = (state_q == ST_IDLE) ? (is_new ? connection_sel : 6'd0) : eff_sel_q;
        scan_start = (state_q == ST_IDLE) ? '0 : slot_q + 5'd1;
        nxt_found  = 1'b0;
        nxt_slot   = '0;
        for (int s = NUM_SEQ_SLOTS - 1; s >= 0; s--) begin
            if (5'(s) >= scan_start && !slot_skipped(slot_decode(5'(s)), scan_sel)) begin
                nxt_found = 1'b1;
                nxt_slot  = 5'(s);
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and sequencing registers; sample_clk_en aborts from any state
    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        idx_d     = idx_q;
        drain_d   = drain_q;
        eff_sel_d = eff_sel_q;
        overrun_d = sample_clk_en && busy;
        if (sample_clk_en) begin
            state_d = ST_IDLE;
            idx_d   = 2'd0;
            drain_d = 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ops_done_pulse) begin
                        eff_sel_d = scan_sel;
                        drain_d   = 2'd0;
                        if (nxt_found) begin
                            state_d = ST_DESC;
                            slot_d  = nxt_slot;
                        end else begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
                ST_DESC: begin
                    if (ch_ready) begin
                        state_d = ST_READ;
                        idx_d   = 2'd0;
                    end
                end
                ST_READ: begin
                    idx_d = idx_q + 2'd1;
                    if (last_rd) begin
                        if (nxt_found) begin
                            state_d = ST_DESC;
                            slot_d  = nxt_slot;
                        end else begin
                            state_d = ST_DRAIN;
                            drain_d = 2'd0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == 2'(MEM_LATENCY - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        drain_d = drain_q + 2'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath registers for the current walk
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            slot_q    <= '0;
            idx_q     <= 2'd0;
            drain_q   <= 2'd0;
            eff_sel_q <= 6'd0;
            overrun_q <= 1'b0;
        end else begin
            slot_q    <= slot_d;
            idx_q     <= idx_d;
            drain_q   <= drain_d;
            eff_sel_q <= eff_sel_d;
            overrun_q <= overrun_d;
        end
    end

    // Moore outputs decoded from state; fields are zero when not presented
    always_comb begin
        ch_valid     = 1'b0;
        ch_bank      = '0;
        ch_num       = '0;
        ch_four_op   = 1'b0;
        op_rd        = 1'b0;
        op_rd_bank   = '0;
        op_rd_op_num = '0;
        busy         = (state_q != ST_IDLE);
        case (state_q)
            ST_DESC: begin
                ch_valid   = 1'b1;
                ch_bank    = cur.bank;
                ch_num     = cur.channel;
                ch_four_op = cur.four_op;
            end
            ST_READ: begin
                op_rd        = 1'b1;
                op_rd_bank   = cur.bank;
                op_rd_op_num = op_num_for(cur, idx_q);
            end
            default: ;
        endcase
    end

    // Tag launched with each read; done marks the final read, or the accept of an empty walk
    always_comb begin
        tag_in       = '0;
        tag_in.valid = op_rd;
        tag_in.idx   = idx_q;
        tag_in.last  = last_rd;
        tag_in.done  = (last_rd && !nxt_found) || (accept && !nxt_found);
    end

    seq_tag_delay #(
        .LATENCY (MEM_LATENCY)
    ) u_tag_delay (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (sample_clk_en),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign op_data_valid = tag_out.valid;
    assign op_data_idx   = tag_out.idx;
    assign op_data_last  = tag_out.last;
    assign seq_done      = tag_out.done;
    assign overrun       = overrun_q;

`ifdef CHANNEL_SEQ_STATS_EN
    logic [7:0] run_cnt_q, run_cnt_d;
    logic [7:0] seq_cycles_q, seq_cycles_d;
    logic [7:0] stall_q, stall_d;

    // Saturating sequence-length and descriptor-stall counters
    always_comb begin
        run_cnt_d    = run_cnt_q;
        seq_cycles_d = seq_cycles_q;
        stall_d      = stall_q;
        if (accept) begin
            run_cnt_d = 8'd1;
        end else if (busy && run_cnt_q != 8'hFF) begin
            run_cnt_d = run_cnt_q + 8'd1;
        end
        if (seq_done) begin
            seq_cycles_d = run_cnt_q;
        end
        if (state_q == ST_DESC && !ch_ready && stall_q != 8'hFF) begin
            stall_d = stall_q + 8'd1;
        end
    end

    // Statistics registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            run_cnt_q    <= 8'd0;
            seq_cycles_q <= 8'd0;
            stall_q      <= 8'd0;
        end else begin
            run_cnt_q    <= run_cnt_d;
            seq_cycles_q <= seq_cycles_d;
            stall_q      <= stall_d;
        end
    end

    assign seq_cycles   = seq_cycles_q;
    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_channel_sequencer.sv
// Directed bench for channel_sequencer with a descriptor/read/tag scoreboard.
// Latency: expected seq_done cycle derived from per-channel cost (3 or 5) plus MEM_LATENCY.
// Backpressure: ch_ready driven from the stimulus sequence.
module tb_channel_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       sample_clk_en;
    logic       ops_done_pulse;
    logic [5:0] connection_sel;
    logic       is_new;
    logic       ch_valid;
    logic       ch_ready;
    logic       ch_bank;
    logic [3:0] ch_num;
    logic       ch_four_op;
    logic       op_rd;
    logic       op_rd_bank;
    logic [4:0] op_rd_op_num;
    logic       op_data_valid;
    logic [1:0] op_data_idx;
    logic       op_data_last;
    logic       seq_done;
    logic       busy;
    logic       overrun;
`ifdef CHANNEL_SEQ_STATS_EN
    logic [7:0] seq_cycles;
    logic [7:0] stall_cycles;
`endif

    channel_sequencer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .sample_clk_en  (sample_clk_en),
        .ops_done_pulse (ops_done_pulse),
        .connection_sel (connection_sel),
        .is_new         (is_new),
        .ch_valid       (ch_valid),
        .ch_ready       (ch_ready),
        .ch_bank        (ch_bank),
        .ch_num         (ch_num),
        .ch_four_op     (ch_four_op),
        .op_rd          (op_rd),
        .op_rd_bank     (op_rd_bank),
        .op_rd_op_num   (op_rd_op_num),
        .op_data_valid  (op_data_valid),
        .op_data_idx    (op_data_idx),
        .op_data_last   (op_data_last),
        .seq_done       (seq_done),
        .busy           (busy),
        .overrun        (overrun)
`ifdef CHANNEL_SEQ_STATS_EN
        ,
        .seq_cycles     (seq_cycles),
        .stall_cycles   (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int c0    = 0;
    int exp_done = -1;
    int n_desc = 0;
    int n_exp_desc = 0;
    logic done_seen = 1'b0;

    // Scoreboard queues: desc {bank,ch[3:0],four_op}, read {bank,op[4:0]}, tag {idx[1:0],last}
    int desc_q[$];
    int rd_q[$];
    int tag_q[$];

    logic [20:0] all_out;
    assign all_out = {ch_valid, ch_bank, ch_num, ch_four_op, op_rd, op_rd_bank, op_rd_op_num,
                      op_data_valid, op_data_idx, op_data_last, seq_done, busy, overrun};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected stream for one walk, derived from the slot order and skip rules
    task automatic build_model(input logic nw, input logic [5:0] sel, input int stall);
        logic [5:0] eff;
        int cost;
        eff = nw ? sel : 6'd0;
        cost = 0;
        n_exp_desc = 0;
        desc_q.delete();
        rd_q.delete();
        tag_q.delete();
        for (int b = 0; b < 2; b++) begin
            for (int c = 0; c < 9; c++) begin
                bit skip;
                int base;
                skip = (c < 3 && eff[b*3+c]) || (c >= 3 && c < 6 && eff[b*3+c-3]);
                if (!skip) begin
                    base = (c < 3) ? c : (c < 6) ? c + 3 : c + 6;
                    desc_q.push_back(b*32 + c*2);
                    rd_q.push_back(b*32 + base);
                    rd_q.push_back(b*32 + base + 3);
                    tag_q.push_back(0);
                    tag_q.push_back(3);
                    cost += 3;
                    n_exp_desc++;
                end
            end
        end
        for (int b = 0; b < 2; b++) begin
            for (int c = 0; c < 3; c++) begin
                if (eff[b*3+c]) begin
                    desc_q.push_back(b*32 + c*2 + 1);
                    for (int k = 0; k < 4; k++) begin
                        rd_q.push_back(b*32 + c + 3*k);
                        tag_q.push_back(k*2 + ((k == 3) ? 1 : 0));
                    end
                    cost += 5;
                    n_exp_desc++;
                end
            end
        end
        exp_done = cost + 1 + stall;
    endtask

    // Drive one ops_done_pulse (relative cycle 0); returns in relative cycle 1
    task automatic start_seq(input logic nw, input logic [5:0] sel, input int stall);
        build_model(nw, sel, stall);
        is_new = nw;
        connection_sel = sel;
        done_seen = 1'b0;
        n_desc = 0;
        c0 = cyc;
        ops_done_pulse = 1'b1;
        tick;
        ops_done_pulse = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done_seen; i++) tick;
        chk("done_timeout", int'(done_seen), 1);
    endtask

    // Scoreboard monitor, sampling on the falling edge
    always @(negedge clk) begin
        if (reset_n) begin
            if (ch_valid && ch_ready) begin
                n_desc++;
                if (desc_q.size() == 0) chk("desc_extra", 1, 0);
                else chk("desc", int'({ch_bank, ch_num, ch_four_op}), desc_q.pop_front());
            end
            if (op_rd) begin
                if (rd_q.size() == 0) chk("read_extra", 1, 0);
                else chk("read_op", int'({op_rd_bank, op_rd_op_num}), rd_q.pop_front());
            end
            if (op_data_valid) begin
                if (tag_q.size() == 0) chk("tag_extra", 1, 0);
                else chk("data_tag", int'({op_data_idx, op_data_last}), tag_q.pop_front());
            end
            if (seq_done) begin
                done_seen = 1'b1;
                chk("seq_done_cycle", cyc - c0, exp_done);
                chk("busy_at_done", int'(busy), 1);
                chk("data_valid_at_done", int'(op_data_valid), 1);
                chk("tags_drained_at_done", tag_q.size(), 0);
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        sample_clk_en = 1'b0;
        ops_done_pulse = 1'b0;
        connection_sel = 6'd0;
        is_new = 1'b0;
        ch_ready = 1'b1;
        repeat (3) tick;
        chk("reset_outputs", int'(all_out), 0);
        reset_n = 1'b1;
        tick;
        chk("idle_busy", int'(busy), 0);

        // All-2-op walk (is_new=0 ignores connection_sel); a pulse while busy is ignored
        start_seq(1'b0, 6'b101010, 0);
        chk("t1_valid_rel1", int'(ch_valid), 1);
        chk("t1_busy_rel1", int'(busy), 1);
        repeat (29) tick;
        ops_done_pulse = 1'b1;
        tick;
        ops_done_pulse = 1'b0;
        wait_done(200);
        chk("t1_desc_count", n_desc, n_exp_desc);
        chk("t1_busy_after", int'(busy), 0);
        chk("t1_reads_left", rd_q.size(), 0);

        // Single 4-op pair enabled in bank0
        start_seq(1'b1, 6'b000001, 0);
        wait_done(200);
        chk("t3_desc_count", n_desc, n_exp_desc);

        // Four-cycle stall on the second descriptor (bank0 ch1)
        start_seq(1'b0, 6'b000000, 4);
        repeat (3) tick;
        ch_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("stall_valid", int'(ch_valid), 1);
            chk("stall_fields", int'({ch_bank, ch_num, ch_four_op}), 6'b0_0001_0);
            chk("stall_no_read", int'(op_rd), 0);
            tick;
        end
        ch_ready = 1'b1;
        wait_done(200);

        // Abort at cycle 20 with a connection_sel write at cycle 10
        start_seq(1'b1, 6'b000000, 0);
        repeat (9) tick;
        connection_sel = 6'b111111;
        repeat (10) tick;
        exp_done = -1;
        sample_clk_en = 1'b1;
        tick;
        sample_clk_en = 1'b0;
        chk("abort_overrun", int'(overrun), 1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_valid", int'(ch_valid), 0);
        chk("abort_data_valid", int'(op_data_valid), 0);
        tick;
        chk("abort_overrun_pulse", int'(overrun), 0);
        repeat (40) tick;
        chk("abort_no_done", int'(done_seen), 0);

        // sample_clk_en with ops_done_pulse in the same cycle drops the pulse
        sample_clk_en = 1'b1;
        ops_done_pulse = 1'b1;
        tick;
        sample_clk_en = 1'b0;
        ops_done_pulse = 1'b0;
        chk("drop_pulse_busy", int'(busy), 0);
        chk("drop_pulse_overrun", int'(overrun), 0);

        // Full 4-op configuration picked up by the next pulse
        start_seq(1'b1, 6'b111111, 0);
        wait_done(200);
        chk("t2_desc_count", n_desc, n_exp_desc);

        // Reset asserted mid-READ, then a clean walk with a mixed selection
        start_seq(1'b0, 6'b000000, 0);
        tick;
        chk("pre_reset_read", int'(op_rd), 1);
        reset_n = 1'b0;
        exp_done = -1;
        tick;
        chk("reset_mid_read_outputs", int'(all_out), 0);
        reset_n = 1'b1;
        repeat (5) tick;
        chk("reset_no_done", int'(done_seen), 0);
        start_seq(1'b1, 6'b100010, 0);
        wait_done(200);
        chk("t6_desc_count", n_desc, n_exp_desc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
